// File: rtl/memory_stage_if.sv
// ---------------------------------------------------------------------------
// memory_stage_if
//   Bundle of the execute-to-memory pipeline inputs and the EX/MEM / MEM/WB
//   register outputs of memory_stage.
//
//   Inputs to the stage (driven by the master side):
//     stall        hold EX/MEM, send a bubble into MEM/WB
//     flush        load a bubble into EX/MEM (wins over stall)
//     ALU_result   execute result / byte address of a memory access
//     Reg2_out     store data
//     R_dest_exec  destination register
//     MemRd        load
//     MemWr        store
//     RegWr        register write
//     WBsel        writeback select (1 = memory data)
//   Outputs of the stage (driven by the slave side):
//     exmem_alu, exmem_rd, exmem_regwr   EX/MEM contents for forwarding
//     wb_data, wb_rd, wb_regwr           MEM/WB contents
//     mem_fault                          registered alignment fault
// ---------------------------------------------------------------------------
interface memory_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] ALU_result;
  logic [31:0] Reg2_out;
  logic [4:0]  R_dest_exec;
  logic        MemRd;
  logic        MemWr;
  logic        RegWr;
  logic        WBsel;

  logic [31:0] exmem_alu;
  logic [4:0]  exmem_rd;
  logic        exmem_regwr;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwr;
  logic        mem_fault;

  // Pipeline front end drives the instruction, observes the registers.
  modport master (
    output stall, flush, ALU_result, Reg2_out, R_dest_exec,
           MemRd, MemWr, RegWr, WBsel,
    input  exmem_alu, exmem_rd, exmem_regwr,
           wb_data, wb_rd, wb_regwr, mem_fault
  );

  // The memory stage itself.
  modport slave (
    input  stall, flush, ALU_result, Reg2_out, R_dest_exec,
           MemRd, MemWr, RegWr, WBsel,
    output exmem_alu, exmem_rd, exmem_regwr,
           wb_data, wb_rd, wb_regwr, mem_fault
  );
endinterface

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Memory stage of a 32-bit pipeline: EX/MEM register, DEPTH-word data
//   memory with registered (read-first) read, and MEM/WB register.
//
//   Ports:
//     clk    single clock, all state updates on the rising edge
//     rst_n  asynchronous active-low reset of the pipeline registers
//            (memory contents are not reset)
//     bus    memory_stage_if.slave, instruction in / pipeline registers out
//
//   Parameter:
//     DEPTH  number of 32-bit memory words; word index is
//            ALU_result[$clog2(DEPTH)+1:2], higher bits ignored.
//
//   Optional feature:
//     MEM_ALIGN_CHECK_EN  when defined, a load/store whose address has
//                         nonzero low two bits is a fault: no store, load
//                         data forced to 0, mem_fault=1 for that
//                         instruction's MEM/WB cycle. When undefined the
//                         low address bits are ignored and mem_fault is 0.
// ---------------------------------------------------------------------------
module memory_stage #(
  parameter int DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_stage_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  // EX/MEM register
  logic [31:0] ex_alu_reg;
  logic [31:0] ex_data_reg;
  logic [4:0]  ex_rd_reg;
  logic        ex_memrd_reg;
  logic        ex_memwr_reg;
  logic        ex_regwr_reg;
  logic        ex_wbsel_reg;

  // MEM/WB register
  logic [31:0] wb_alu_reg;
  logic [4:0]  wb_rd_reg;
  logic        wb_regwr_reg;
  logic        wb_sel_reg;

  // Data memory and its output register (not reset so it maps to block RAM)
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_reg;

  logic [AW-1:0] ex_idx;
  logic          ex_misalign;
  logic          mem_we;
  logic          mem_re;

  assign ex_idx = ex_alu_reg[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign ex_misalign = (ex_memrd_reg | ex_memwr_reg) && (ex_alu_reg[1:0] != 2'b00);
`else
  assign ex_misalign = 1'b0;
`endif

  // A store commits on the edge that moves it out of EX/MEM. While stalled
  // it stays in EX/MEM and writes on the release edge, so exactly once.
  // rst_n in the enable keeps a store that is in flight at reset from
  // landing on the edge where reset is still asserted.
  assign mem_we = rst_n && ex_memwr_reg && !bus.stall && !ex_misalign;
  assign mem_re = ex_memrd_reg && !bus.stall;

  // ---------------- EX/MEM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_alu_reg   <= '0;
      ex_data_reg  <= '0;
      ex_rd_reg    <= '0;
      ex_memrd_reg <= 1'b0;
      ex_memwr_reg <= 1'b0;
      ex_regwr_reg <= 1'b0;
      ex_wbsel_reg <= 1'b0;
    end else if (bus.flush) begin
      ex_alu_reg   <= '0;
      ex_data_reg  <= '0;
      ex_rd_reg    <= '0;
      ex_memrd_reg <= 1'b0;
      ex_memwr_reg <= 1'b0;
      ex_regwr_reg <= 1'b0;
      ex_wbsel_reg <= 1'b0;
    end else if (!bus.stall) begin
      ex_alu_reg   <= bus.ALU_result;
      ex_data_reg  <= bus.Reg2_out;
      ex_rd_reg    <= bus.R_dest_exec;
      ex_memrd_reg <= bus.MemRd;
      ex_memwr_reg <= bus.MemWr;
      ex_regwr_reg <= bus.RegWr;
      ex_wbsel_reg <= bus.WBsel;
    end
  end

  // ---------------- Data memory ----------------
  // Read-first: a load+store to the same word returns the old word, and a
  // load following a store sees the store, which committed one edge earlier.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ex_idx] <= ex_data_reg;
    end
    if (mem_re) begin
      rd_word_reg <= mem[ex_idx];
    end
  end

  // ---------------- MEM/WB ----------------
  // The memory word lives in rd_word_reg; wb_sel_reg picks it or the ALU
  // value. Clearing wb_sel_reg and wb_alu_reg makes wb_data 0 on reset
  // and on stall bubbles without resetting the RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_alu_reg   <= '0;
      wb_rd_reg    <= '0;
      wb_regwr_reg <= 1'b0;
      wb_sel_reg   <= 1'b0;
    end else if (bus.stall) begin
      wb_alu_reg   <= '0;
      wb_rd_reg    <= '0;
      wb_regwr_reg <= 1'b0;
      wb_sel_reg   <= 1'b0;
    end else begin
      wb_alu_reg   <= ex_alu_reg;
      wb_rd_reg    <= ex_rd_reg;
      wb_regwr_reg <= ex_regwr_reg;
      wb_sel_reg   <= ex_wbsel_reg;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic wb_fault_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_fault_reg <= 1'b0;
    end else if (bus.stall) begin
      wb_fault_reg <= 1'b0;
    end else begin
      wb_fault_reg <= ex_misalign;
    end
  end

  assign bus.wb_data   = wb_sel_reg ? (wb_fault_reg ? 32'h0 : rd_word_reg) : wb_alu_reg;
  assign bus.mem_fault = wb_fault_reg;
`else
  assign bus.wb_data   = wb_sel_reg ? rd_word_reg : wb_alu_reg;
  assign bus.mem_fault = 1'b0;
`endif

  assign bus.exmem_alu   = ex_alu_reg;
  assign bus.exmem_rd    = ex_rd_reg;
  assign bus.exmem_regwr = ex_regwr_reg;
  assign bus.wb_rd       = wb_rd_reg;
  assign bus.wb_regwr    = wb_regwr_reg;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//   Self-checking bench for memory_stage: directed scenarios followed by
//   randomized instruction streams, compared each cycle against a
//   transaction-level reference (word array + in-flight instruction).
// ---------------------------------------------------------------------------
module tb_memory_stage;

  localparam int DEPTH = 256;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if bus ();

  memory_stage #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        memrd;
    logic        memwr;
    logic        regwr;
    logic        wbsel;
  } instr_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwr;
    logic        fault;
  } wb_t;

  // Reference state: instruction waiting in the memory stage, the value
  // retired toward writeback, and the contents of data memory.
  instr_t      cur_in;
  logic        cur_stall;
  logic        cur_flush;
  instr_t      m_ex;
  wb_t         m_wb;
  logic [31:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] data,
                                input logic [4:0] rd, input logic memrd,
                                input logic memwr, input logic regwr, input logic wbsel);
    instr_t i;
    i.alu = alu; i.data = data; i.rd = rd;
    i.memrd = memrd; i.memwr = memwr; i.regwr = regwr; i.wbsel = wbsel;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input instr_t i, input logic st, input logic fl);
    cur_in = i; cur_stall = st; cur_flush = fl;
    bus.stall       = st;
    bus.flush       = fl;
    bus.ALU_result  = i.alu;
    bus.Reg2_out    = i.data;
    bus.R_dest_exec = i.rd;
    bus.MemRd       = i.memrd;
    bus.MemWr       = i.memwr;
    bus.RegWr       = i.regwr;
    bus.WBsel       = i.wbsel;
  endtask

  task automatic model_reset();
    m_ex = '0;
    m_wb = '0;
  endtask

  // One rising edge of the pipeline, expressed as instruction movement.
  task automatic model_edge();
    int   idx;
    logic fault;
    idx = int'((m_ex.alu / 4) % DEPTH);
    if (cur_stall) begin
      m_wb = '0;
    end else begin
      fault = ALIGN && (m_ex.memrd || m_ex.memwr) && (m_ex.alu % 4 != 0);
      m_wb.data  = m_ex.wbsel ? (fault ? 32'h0 : ref_mem[idx]) : m_ex.alu;
      m_wb.rd    = m_ex.rd;
      m_wb.regwr = m_ex.regwr;
      m_wb.fault = fault;
      if (m_ex.memwr && !fault) ref_mem[idx] = m_ex.data;
    end
    if (cur_flush)       m_ex = '0;
    else if (!cur_stall) m_ex = cur_in;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".exmem_alu"},   bus.exmem_alu,   m_ex.alu);
    check({ctx, ".exmem_rd"},    bus.exmem_rd,    m_ex.rd);
    check({ctx, ".exmem_regwr"}, bus.exmem_regwr, m_ex.regwr);
    check({ctx, ".wb_data"},     bus.wb_data,     m_wb.data);
    check({ctx, ".wb_rd"},       bus.wb_rd,       m_wb.rd);
    check({ctx, ".wb_regwr"},    bus.wb_regwr,    m_wb.regwr);
    check({ctx, ".mem_fault"},   bus.mem_fault,   m_wb.fault);
  endtask

  task automatic tick(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ctx);
  endtask

  initial begin
    logic [31:0] old_word;
    logic [31:0] alu;
    instr_t      ins;
    int          kind;

    drive(nop(), 1'b0, 1'b0);
    model_reset();

    // Reset asserts asynchronously and clears every output.
    #1 rst_n = 1'b0;
    #1 compare_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) begin
      drive(mk(w * 4, $urandom, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
      tick("fill");
    end
    drive(nop(), 1'b0, 1'b0);
    tick("fill");

    // ALU pass-through: one edge to EX/MEM, one more to writeback.
    drive(mk(32'h1234, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0);
    tick("alu");
    check("alu.exmem_alu", bus.exmem_alu, 32'h1234);
    drive(nop(), 1'b0, 1'b0);
    tick("alu");
    check("alu.wb_data", bus.wb_data, 32'h1234);
    check("alu.wb_rd", bus.wb_rd, 32'd3);

    // Store then immediately load the same word.
    drive(mk(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    tick("st_ld");
    drive(mk(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    tick("st_ld");
    drive(nop(), 1'b0, 1'b0);
    tick("st_ld");
    check("st_ld.wb_data", bus.wb_data, 32'hDEADBEEF);
    check("st_ld.wb_rd", bus.wb_rd, 32'd5);
    check("st_ld.wb_regwr", bus.wb_regwr, 32'd1);

    // Store held by a 3-cycle stall, written on release.
    drive(mk(32'h20, 32'h11, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    tick("stall");
    for (int s = 0; s < 3; s++) begin
      drive(mk(32'h999, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
      tick("stall");
      check("stall.exmem_alu_held", bus.exmem_alu, 32'h20);
      check("stall.wb_regwr", bus.wb_regwr, 32'd0);
    end
    drive(nop(), 1'b0, 1'b0);
    tick("stall");
    drive(mk(32'h20, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    tick("stall");
    drive(nop(), 1'b0, 1'b0);
    tick("stall");
    check("stall.word", bus.wb_data, 32'h11);

    // Flush wins over stall: the store never enters EX/MEM.
    old_word = ref_mem[12];
    drive(mk(32'h30, 32'h77, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
    tick("flush");
    check("flush.exmem_alu", bus.exmem_alu, 32'h0);
    drive(nop(), 1'b0, 1'b0);
    tick("flush");
    drive(mk(32'h30, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    tick("flush");
    drive(nop(), 1'b0, 1'b0);
    tick("flush");
    check("flush.word", bus.wb_data, old_word);

    // Misaligned store.
    old_word = ref_mem[16];
    drive(mk(32'h41, 32'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    tick("align");
    drive(nop(), 1'b0, 1'b0);
    tick("align");
    check("align.fault", bus.mem_fault, ALIGN ? 32'd1 : 32'd0);
    tick("align");
    check("align.fault_clear", bus.mem_fault, 32'd0);
    drive(mk(32'h40, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    tick("align");
    drive(nop(), 1'b0, 1'b0);
    tick("align");
    check("align.word", bus.wb_data, ALIGN ? old_word : 32'hAA);

    // Reset while a store sits in EX/MEM: outputs clear at once, no write.
    old_word = ref_mem[20];
    drive(mk(32'h50, 32'h5555AAAA, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    tick("rst_mid");
    drive(nop(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(mk(32'h50, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
    tick("rst_mid");
    drive(nop(), 1'b0, 1'b0);
    tick("rst_mid");
    check("rst_mid.word", bus.wb_data, old_word);

    // Randomized stream; a small index range forces address reuse and
    // random high bits exercise the wrap.
    for (int c = 0; c < 400; c++) begin
      alu = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) alu[1:0] = 2'($urandom_range(1, 3));
      kind = $urandom_range(0, 3);
      case (kind)
        0:       ins = mk(alu, $urandom, 5'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b0);
        1:       ins = mk(alu, $urandom, 5'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b1);
        2:       ins = mk(alu, $urandom, 5'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        default: ins = mk(alu, $urandom, 5'($urandom), 1'b1, 1'b1, 1'($urandom), 1'b1);
      endcase
      drive(ins, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      tick("rand");
    end

    drive(nop(), 1'b0, 1'b0);
    tick("drain");
    tick("drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit data-memory words; word index = ALU_result[log2(DEPTH)+1:2].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 stall  input  1  hold EX/MEM register.
REQ-005 flush  input  1  load bubble into EX/MEM register.
REQ-006 ALU_result  input  32  execute-stage result / memory byte address.
REQ-007 Reg2_out  input  32  store data.
REQ-008 R_dest_exec  input  5  destination register.
REQ-009 MemRd, MemWr, RegWr, WBsel  input  1 each  load, store, register write, writeback select (1 = memory data).
REQ-010 exmem_alu  output  32; exmem_rd  output  5; exmem_regwr  output  1  EX/MEM contents for forwarding.
REQ-011 wb_data  output  32; wb_rd  output  5; wb_regwr  output  1  MEM/WB contents.
REQ-012 mem_fault  output  1  registered alignment fault (see Configuration).

Function
REQ-013 Two register stages, EX/MEM and MEM/WB; an instruction presented in cycle N appears on exmem_* after edge N and on wb_* after edge N+1.
REQ-014 EX/MEM captures ALU_result, Reg2_out, R_dest_exec, MemRd, MemWr, RegWr, WBsel each edge when stall=0 and flush=0.
REQ-015 flush=1: EX/MEM captures a bubble (all control bits 0, data 0); flush overrides stall.
REQ-016 stall=1, flush=0: EX/MEM holds; MEM/WB captures a bubble (wb_regwr=0); no memory write.
REQ-017 Store: memory word written with stored Reg2_out at the edge where EX/MEM MemWr=1 and stall=0; written exactly once per instruction.
REQ-018 Load: synchronous read; memory word captured into MEM/WB at the edge ending the EX/MEM cycle.
REQ-019 wb_data = memory word when WBsel=1, else EX/MEM ALU value; wb_rd and wb_regwr copy EX/MEM values.
REQ-020 Load immediately after a store to the same word returns the newly stored value (store in MEM/WB-bound edge precedes next load read; read-after-write within same edge not required).
REQ-021 Address bits above the index are ignored (wrap modulo DEPTH).
REQ-022 MemRd and MemWr both 1: store performed, wb_data = old word.

Reset
REQ-023 rst_n=0 immediately clears EX/MEM and MEM/WB registers: all exmem_*, wb_*, mem_fault = 0.
REQ-024 Memory array contents are not reset; store in flight at reset assertion is discarded.
REQ-025 Release of rst_n is synchronised by the surrounding design; first capture on the first edge with rst_n=1.

Configuration
REQ-026 Macro MEM_ALIGN_CHECK_EN defined: access (MemRd or MemWr) with ALU_result[1:0] != 0 suppresses the store, forces wb_data=0 for loads, sets mem_fault=1 in MEM/WB for that instruction only.
REQ-027 MEM_ALIGN_CHECK_EN undefined: ALU_result[1:0] ignored, mem_fault tied 0, no extra logic.

Verification
REQ-028 Reset mid-stream: rst_n low while store in EX/MEM -> all outputs 0 immediately, target word unchanged.
REQ-029 Store 0xDEADBEEF to 0x10, next cycle load 0x10 RegWr=1 WBsel=1 Rd=5 -> wb_data=0xDEADBEEF, wb_rd=5, wb_regwr=1 two edges after load presented.
REQ-030 ALU op ALU_result=0x1234, WBsel=0, Rd=3 -> exmem_alu=0x1234 after edge 1, wb_data=0x1234 after edge 2.
REQ-031 Store 0x11 to 0x20 with stall=1 for 3 cycles -> exmem_* held, wb_regwr=0 during stall, word written once on release.
REQ-032 flush=1 and stall=1 with store to 0x30 -> EX/MEM bubble, word 0x30 unchanged.
REQ-033 MEM_ALIGN_CHECK_EN: store 0xAA to 0x41 -> no write, mem_fault=1 for one cycle; undefined: word 0x40 = 0xAA, mem_fault=0.
